// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM state encoding and fetch geometry.
// Pure declarations; no timing or flow-control behaviour of its own.
package fetch_pkg;

    localparam int unsigned BYTES_PER_INSTR = 4;
    localparam int unsigned CNT_W           = 2;
    localparam logic [CNT_W-1:0] CNT_LAST   = 2'd3;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_WAIT_LAST = 3'd1,
        ST_HOLD      = 3'd2,
        ST_LOAD      = 3'd3,
        ST_ERR       = 3'd4
    } fetch_state_t;

    // A fetch PC must be word aligned with the whole word inside memory.
    function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] mem_bytes);
        return (pc[1:0] == 2'b00) && (pc <= mem_bytes - 32'(BYTES_PER_INSTR));
    endfunction

endpackage

// File: rtl/instr_byte_assembler.sv
// Collects four memory bytes into a big-endian word; one byte per shift, clear has priority.
// Single-cycle update; no backpressure (the caller decides when to shift).
module instr_byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  din,
    output logic [31:0] word
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            word <= 32'h0;
        end else if (shift) begin
            word <= {word[23:0], din};
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: four byte reads per instruction, valid 5 cycles after first issue, 6-cycle throughput.
// Holds the instruction until decode accepts it; the byte loader preempts fetch and owns the memory port.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 400,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        fetch_err
);

    fetch_state_t     state;
    logic [CNT_W-1:0] byte_cnt;
    logic [31:0]      pc;
    logic [31:0]      pc_seq;
    logic [31:0]      tgt;
    logic             tgt_ok;
    logic             xfer;
    logic             launch;
    logic             asm_clear;
    logic             asm_shift;

    assign xfer   = out_valid && out_ready;
    assign pc_seq = pc + 32'(BYTES_PER_INSTR);

    // Where the next fetch starts when one is launched this edge.
    always_comb begin
        tgt = pc;
        if (state != ST_LOAD && redirect_valid) begin
            tgt = redirect_pc;
        end else if (state == ST_HOLD) begin
            tgt = pc_seq;
        end
    end

    assign tgt_ok = pc_legal(tgt, 32'(MEM_BYTES));

    // A launch preloads mem_addr so the first byte is issued the very next cycle.
    always_comb begin
        launch = 1'b0;
        if (state == ST_LOAD) begin
            launch = !ld_valid;
        end else if (!ld_valid) begin
            launch = redirect_valid || (state == ST_HOLD && out_ready);
        end
    end

    always_comb begin
        asm_clear = 1'b0;
        asm_shift = 1'b0;
        if (state != ST_LOAD && (ld_valid || redirect_valid)) begin
            asm_clear = 1'b1;
        end else if (state == ST_FETCH && byte_cnt != '0) begin
            asm_shift = 1'b1;
        end else if (state == ST_WAIT_LAST) begin
            asm_shift = 1'b1;
        end
    end

    instr_byte_assembler u_asm (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (asm_clear),
        .shift (asm_shift),
        .din   (mem_rdata),
        .word  (out_instr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            byte_cnt  <= '0;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_pc    <= 32'h0;
            mem_addr  <= RESET_PC;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            ld_ready  <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (state == ST_LOAD) begin
                if (ld_valid) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ld_addr;
                    mem_wdata <= ld_data;
                end else begin
                    ld_ready <= 1'b0;
                end
            end else if (ld_valid) begin
                // Switch cycle: the loader byte is not accepted until LOAD is entered.
                state     <= ST_LOAD;
                ld_ready  <= 1'b1;
                out_valid <= 1'b0;
                byte_cnt  <= '0;
                if (xfer) begin
                    pc <= pc_seq;
                end
            end else if (!launch) begin
                unique case (state)
                    ST_FETCH: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == CNT_LAST) begin
                            state <= ST_WAIT_LAST;
                        end else begin
                            mem_addr <= pc + 32'(byte_cnt) + 32'd1;
                        end
                    end
                    ST_WAIT_LAST: begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                        out_pc    <= pc;
                    end
                    default: begin
                    end
                endcase
            end

            if (launch) begin
                pc        <= tgt;
                byte_cnt  <= '0;
                out_valid <= 1'b0;
                if (tgt_ok) begin
                    state     <= ST_FETCH;
                    mem_addr  <= tgt;
                    fetch_err <= 1'b0;
                end else begin
                    state     <= ST_ERR;
                    fetch_err <= 1'b1;
                end
            end
        end
    end

endmodule
